// File: rtl/multi_clock_divider_if.sv
// Control and status bundle for multi_clock_divider: per-channel enables,
// the shared divisor load port, and the per-channel divided outputs.
interface multi_clock_divider_if #(
   parameter int N_CHANNELS = 4,
   parameter int WIDTH      = 32
);
   localparam int CH_BITS = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

   logic [N_CHANNELS-1:0] i_ENABLE;
   logic                  i_LOAD;
   logic [CH_BITS-1:0]    i_LOAD_CHANNEL;
   logic [WIDTH-1:0]      i_LOAD_DIVISOR;
   logic [N_CHANNELS-1:0] o_CLOCK;
   logic [N_CHANNELS-1:0] o_TICK;
   logic [N_CHANNELS-1:0] o_RUNNING;

   modport master (
      output i_ENABLE,
      output i_LOAD,
      output i_LOAD_CHANNEL,
      output i_LOAD_DIVISOR,
      input  o_CLOCK,
      input  o_TICK,
      input  o_RUNNING
   );

   modport slave (
      input  i_ENABLE,
      input  i_LOAD,
      input  i_LOAD_CHANNEL,
      input  i_LOAD_DIVISOR,
      output o_CLOCK,
      output o_TICK,
      output o_RUNNING
   );
endinterface

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider. Each channel counts 0..act-1 and
// drives a registered divided clock (low for floor(act/2) cycles, then high)
// plus a one-cycle tick on the last count of every period. Divisor loads go
// to a shadow register and only reach the active divisor at the period
// boundary, so a running output never sees a short or stretched pulse.
module multi_clock_divider #(
   parameter int               N_CHANNELS      = 4,
   parameter int               WIDTH           = 32,
   parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(2)
) (
   input logic                  i_SYS_CLOCK,
   input logic                  i_RESET,
   multi_clock_divider_if.slave bus
);
   localparam int CH_BITS = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

   logic [WIDTH-1:0]      cnt_q [N_CHANNELS];
   logic [WIDTH-1:0]      act_q [N_CHANNELS];
   logic [WIDTH-1:0]      shd_q [N_CHANNELS];
   logic [WIDTH-1:0]      cnt_d [N_CHANNELS];
   logic [WIDTH-1:0]      act_d [N_CHANNELS];
   logic [WIDTH-1:0]      shd_d [N_CHANNELS];
   logic [N_CHANNELS-1:0] clk_q, tick_q, run_q;
   logic [N_CHANNELS-1:0] clk_d, tick_d, run_d;
   logic [N_CHANNELS-1:0] load_hit;
   logic [N_CHANNELS-1:0] run_now;
   logic [N_CHANNELS-1:0] wrap;

   // Decode the shared load port into a per-channel strike; out-of-range channels hit nothing
   always_comb begin
      load_hit = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         load_hit[c] = bus.i_LOAD
                       && (int'(bus.i_LOAD_CHANNEL) < N_CHANNELS)
                       && (int'(bus.i_LOAD_CHANNEL) == c);
      end
   end

   // A channel counts only when enabled with a divisor of at least 2; wrap marks its last count
   always_comb begin
      run_now = '0;
      wrap    = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         run_now[c] = bus.i_ENABLE[c] && (act_q[c] >= WIDTH'(2));
         wrap[c]    = (cnt_q[c] == (act_q[c] - WIDTH'(1)));
      end
   end

   // Next counter, divisor and output values; stopped channels hold cnt at 0 and accept loads directly
   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         cnt_d[c]  = cnt_q[c];
         act_d[c]  = act_q[c];
         shd_d[c]  = load_hit[c] ? bus.i_LOAD_DIVISOR : shd_q[c];
         clk_d[c]  = 1'b0;
         tick_d[c] = 1'b0;
         if (run_now[c]) begin
            cnt_d[c]  = wrap[c] ? '0 : (cnt_q[c] + WIDTH'(1));
            clk_d[c]  = (cnt_q[c] >= (act_q[c] >> 1));
            tick_d[c] = wrap[c];
            if (wrap[c]) begin
               act_d[c] = load_hit[c] ? bus.i_LOAD_DIVISOR : shd_q[c];
            end
         end else begin
            cnt_d[c] = '0;
            if (load_hit[c]) begin
               act_d[c] = bus.i_LOAD_DIVISOR;
            end
         end
         run_d[c] = bus.i_ENABLE[c] && (act_d[c] >= WIDTH'(2));
      end
   end

   // Channel state and registered outputs, with reset taking priority over every load and enable
   always_ff @(posedge i_SYS_CLOCK) begin
      if (i_RESET) begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            cnt_q[c] <= '0;
            act_q[c] <= DEFAULT_DIVISOR;
            shd_q[c] <= DEFAULT_DIVISOR;
         end
         clk_q  <= '0;
         tick_q <= '0;
         run_q  <= '0;
      end else begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            cnt_q[c] <= cnt_d[c];
            act_q[c] <= act_d[c];
            shd_q[c] <= shd_d[c];
         end
         clk_q  <= clk_d;
         tick_q <= tick_d;
         run_q  <= run_d;
      end
   end

   assign bus.o_CLOCK   = clk_q;
   assign bus.o_TICK    = tick_q;
   assign bus.o_RUNNING = run_q;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: a period/phase model of every
// channel is compared against the outputs each cycle, and literal waveforms
// for the directed scenarios pin the model itself.
module tb_multi_clock_divider;
   localparam int               N   = 3;
   localparam int               W   = 32;
   localparam logic [W-1:0]     DEF = 2;

   logic i_SYS_CLOCK = 1'b0;
   logic i_RESET;

   multi_clock_divider_if #(.N_CHANNELS(N), .WIDTH(W)) bus ();

   multi_clock_divider #(
      .N_CHANNELS(N),
      .WIDTH(W),
      .DEFAULT_DIVISOR(DEF)
   ) dut (
      .i_SYS_CLOCK(i_SYS_CLOCK),
      .i_RESET(i_RESET),
      .bus(bus)
   );

   // Free-running system clock
   always #5 i_SYS_CLOCK = ~i_SYS_CLOCK;

   int   total = 0;
   int   bad   = 0;
   bit   checkEn = 1'b0;
   bit   hit;

   logic [W-1:0] mPos [N];
   logic [W-1:0] mAct [N];
   logic [W-1:0] mShd [N];
   logic [N-1:0] eClk, eTick, eRun;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] en, input logic ld, input logic [1:0] ch,
                                input logic [W-1:0] dv);
      bus.i_ENABLE       = en;
      bus.i_LOAD         = ld;
      bus.i_LOAD_CHANNEL = ch;
      bus.i_LOAD_DIVISOR = dv;
   endtask

   // Model: each channel sits at a phase within a period of mAct cycles; the
   // first half (rounded down) is low, the tick marks the final phase, and a
   // new period adopts the most recently requested divisor
   always @(posedge i_SYS_CLOCK) begin
      if (i_RESET) begin
         for (int c = 0; c < N; c++) begin
            mPos[c] = 0;
            mAct[c] = DEF;
            mShd[c] = DEF;
         end
         eClk  = '0;
         eTick = '0;
         eRun  = '0;
      end else begin
         for (int c = 0; c < N; c++) begin
            hit = bus.i_LOAD && (int'(bus.i_LOAD_CHANNEL) == c);
            if (bus.i_ENABLE[c] && mAct[c] >= 2) begin
               eClk[c]  = (mPos[c] >= mAct[c] / 2);
               eTick[c] = (mPos[c] + 1 == mAct[c]);
               mPos[c]  = (mPos[c] + 1) % mAct[c];
               if (mPos[c] == 0) mAct[c] = hit ? bus.i_LOAD_DIVISOR : mShd[c];
               if (hit) mShd[c] = bus.i_LOAD_DIVISOR;
            end else begin
               mPos[c]  = 0;
               eClk[c]  = 1'b0;
               eTick[c] = 1'b0;
               if (hit) begin
                  mAct[c] = bus.i_LOAD_DIVISOR;
                  mShd[c] = bus.i_LOAD_DIVISOR;
               end
            end
            eRun[c] = bus.i_ENABLE[c] && (mAct[c] >= 2);
         end
      end
   end

   // Compare every channel against the model on each falling edge
   always @(negedge i_SYS_CLOCK) begin
      if (checkEn) begin
         for (int c = 0; c < N; c++) begin
            checkOutput($sformatf("model_clk%0d", c),  bus.o_CLOCK[c],   eClk[c]);
            checkOutput($sformatf("model_tick%0d", c), bus.o_TICK[c],    eTick[c]);
            checkOutput($sformatf("model_run%0d", c),  bus.o_RUNNING[c], eRun[c]);
         end
      end
   end

   initial begin
      logic [3:0]  p4;
      logic [9:0]  p10;
      logic [9:0]  t10;
      logic [11:0] p12;
      logic [2:0]  p3;

      i_RESET = 1'b1;
      applyStimulus('0, 1'b0, 2'd0, '0);
      repeat (2) @(negedge i_SYS_CLOCK);
      checkEn = 1'b1;
      checkOutput("rst_clock",   32'(bus.o_CLOCK),   0);
      checkOutput("rst_tick",    32'(bus.o_TICK),    0);
      checkOutput("rst_running", 32'(bus.o_RUNNING), 0);

      // T1: default divisor 2 on ch0
      i_RESET = 1'b0;
      applyStimulus(3'b001, 1'b0, 2'd0, '0);
      p4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_SYS_CLOCK);
         checkOutput("t1_clk0",  32'(bus.o_CLOCK[0]), 32'(p4[i]));
         checkOutput("t1_tick0", 32'(bus.o_TICK[0]),  32'(p4[i]));
         if (i == 0) checkOutput("t1_running", 32'(bus.o_RUNNING), 32'b001);
      end

      // T2: ch1 divide by 5
      applyStimulus(3'b001, 1'b1, 2'd1, 5);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b011, 1'b0, 2'd0, '0);
      p10 = 10'b1110011100;
      t10 = 10'b1000010000;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_SYS_CLOCK);
         checkOutput("t2_clk1",  32'(bus.o_CLOCK[1]), 32'(p10[i]));
         checkOutput("t2_tick1", 32'(bus.o_TICK[1]),  32'(t10[i]));
      end

      // T3: ch0 at 4, reload to 6 mid-period
      applyStimulus(3'b010, 1'b1, 2'd0, 4);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b011, 1'b0, 2'd0, '0);
      p10 = 10'b1110001100;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_SYS_CLOCK);
         checkOutput("t3_clk0", 32'(bus.o_CLOCK[0]), 32'(p10[i]));
         if (i == 0) applyStimulus(3'b011, 1'b1, 2'd0, 6);
         else        applyStimulus(3'b011, 1'b0, 2'd0, '0);
      end

      // T4: load landing exactly on the wrap cycle
      applyStimulus(3'b010, 1'b1, 2'd0, 4);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b011, 1'b0, 2'd0, '0);
      p12 = 12'b111100001100;
      for (int i = 0; i < 12; i++) begin
         @(negedge i_SYS_CLOCK);
         checkOutput("t4_clk0", 32'(bus.o_CLOCK[0]), 32'(p12[i]));
         if (i == 2) applyStimulus(3'b011, 1'b1, 2'd0, 8);
         else        applyStimulus(3'b011, 1'b0, 2'd0, '0);
      end

      // T5: stop ch2 with divisor 0, restart with 3, then drop enable
      applyStimulus(3'b011, 1'b1, 2'd2, 3);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b111, 1'b0, 2'd0, '0);
      repeat (4) @(negedge i_SYS_CLOCK);
      applyStimulus(3'b111, 1'b1, 2'd2, 0);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b111, 1'b0, 2'd0, '0);
      repeat (3) @(negedge i_SYS_CLOCK);
      checkOutput("t5_stop_run2", 32'(bus.o_RUNNING[2]), 0);
      checkOutput("t5_stop_clk2", 32'(bus.o_CLOCK[2]),   0);
      applyStimulus(3'b111, 1'b1, 2'd2, 3);
      @(negedge i_SYS_CLOCK);
      checkOutput("t5_restart_run2", 32'(bus.o_RUNNING[2]), 1);
      checkOutput("t5_restart_clk2", 32'(bus.o_CLOCK[2]),   0);
      applyStimulus(3'b111, 1'b0, 2'd0, '0);
      p3 = 3'b110;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_SYS_CLOCK);
         checkOutput("t5_clk2", 32'(bus.o_CLOCK[2]), 32'(p3[i]));
      end
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b011, 1'b0, 2'd0, '0);
      @(negedge i_SYS_CLOCK);
      checkOutput("t5_disable_clk2",  32'(bus.o_CLOCK[2]),   0);
      checkOutput("t5_disable_tick2", 32'(bus.o_TICK[2]),    0);
      checkOutput("t5_disable_run2",  32'(bus.o_RUNNING[2]), 0);

      // T6: reset with a pending load, then an out-of-range load
      applyStimulus(3'b011, 1'b1, 2'd1, 7);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b011, 1'b0, 2'd0, '0);
      i_RESET = 1'b1;
      @(negedge i_SYS_CLOCK);
      checkOutput("t6_rst_clock",   32'(bus.o_CLOCK),   0);
      checkOutput("t6_rst_tick",    32'(bus.o_TICK),    0);
      checkOutput("t6_rst_running", 32'(bus.o_RUNNING), 0);
      i_RESET = 1'b0;
      p4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_SYS_CLOCK);
         checkOutput("t6_default_clk1", 32'(bus.o_CLOCK[1]), 32'(p4[i]));
      end
      applyStimulus(3'b000, 1'b1, 2'd3, 9);
      @(negedge i_SYS_CLOCK);
      applyStimulus(3'b111, 1'b0, 2'd0, '0);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_SYS_CLOCK);
         for (int c = 0; c < N; c++) begin
            checkOutput($sformatf("t6_range_clk%0d", c), 32'(bus.o_CLOCK[c]), 32'(p4[i]));
         end
      end

      applyStimulus('0, 1'b0, 2'd0, '0);
      @(negedge i_SYS_CLOCK);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
